// File: rtl/uart_tx_arb.sv
// Four-way round-robin arbiter that feeds bytes into a UART TX register bus.
// Also programs the baud period after reset and on request.
module uart_tx_arb #(
    parameter logic [7:0] INIT_PERIOD = 8'h1A
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    input  logic        cfg_we,
    input  logic [7:0]  cfg_period,
    output logic        u_wren,
    output logic        u_rden,
    output logic [2:0]  u_addr,
    output logic [7:0]  u_din,
    input  logic [7:0]  u_dout,
    output logic        busy,
    output logic [1:0]  grant_id
);

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned ID_W   = 2;

    localparam logic [ADDR_W-1:0] ADDR_PERIOD = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_TXDATA = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(3);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CFG,
        S_STAT,
        S_CHECK,
        S_WRITE
    } state_t;

    typedef struct packed {
        logic              wren;
        logic              rden;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
    } ubus_t;

    state_t                        state_q, state_d;
    logic [ID_W-1:0]               grant_id_q;
    logic [DATA_W-1:0]             hold_q;
    logic                          cfg_pend_q;
    logic [DATA_W-1:0]             cfg_period_q;

    logic [N_REQ-1:0][DATA_W-1:0]  req_bytes;
    logic                          pick_valid;
    logic [ID_W-1:0]               pick_id;
    logic [ID_W-1:0]               scan_id;
    logic                          grant_en;
    logic                          cfg_clr;
    ubus_t                         bus;
    logic [N_REQ-1:0]              ready_raw;
    logic                          unused_dout;

    assign req_bytes   = req_data;
    assign unused_dout = ^u_dout[DATA_W-1:1];

    // Round-robin pick: first valid requester after the last grant, wrapping mod 4.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        scan_id    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_id = grant_id_q + ID_W'(k + 1);
            if (!pick_valid && req_valid[scan_id]) begin
                pick_valid = 1'b1;
                pick_id    = scan_id;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and bus outputs; pending configuration beats queued bytes in IDLE.
    always_comb begin
        state_d   = state_q;
        bus       = '0;
        ready_raw = '0;
        grant_en  = 1'b0;
        cfg_clr   = 1'b0;
        unique case (state_q)
            S_INIT: begin
                bus.wren = 1'b1;
                bus.addr = ADDR_PERIOD;
                bus.din  = INIT_PERIOD;
                state_d  = S_IDLE;
            end
            S_IDLE: begin
                if (cfg_pend_q) begin
                    state_d = S_CFG;
                end else if (pick_valid) begin
                    ready_raw = N_REQ'(1) << pick_id;
                    grant_en  = 1'b1;
                    state_d   = S_STAT;
                end
            end
            S_CFG: begin
                bus.wren = 1'b1;
                bus.addr = ADDR_PERIOD;
                bus.din  = cfg_period_q;
                cfg_clr  = 1'b1;
                state_d  = S_IDLE;
            end
            S_STAT: begin
                bus.rden = 1'b1;
                bus.addr = ADDR_STATUS;
                state_d  = S_CHECK;
            end
            S_CHECK: begin
                state_d = u_dout[0] ? S_STAT : S_WRITE;
            end
            S_WRITE: begin
                bus.wren = 1'b1;
                bus.addr = ADDR_TXDATA;
                bus.din  = hold_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Bus and handshake stay quiet while reset is held, even though state reads INIT.
    always_comb begin
        u_wren    = 1'b0;
        u_rden    = 1'b0;
        u_addr    = '0;
        u_din     = '0;
        req_ready = '0;
        if (reset_n) begin
            u_wren    = bus.wren;
            u_rden    = bus.rden;
            u_addr    = bus.addr;
            u_din     = bus.din;
            req_ready = ready_raw;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_id_q <= ID_W'(N_REQ - 1);
            hold_q     <= '0;
        end else if (grant_en) begin
            grant_id_q <= pick_id;
            hold_q     <= req_bytes[pick_id];
        end
    end

    // A new request in the same cycle as service keeps the flag set (last value wins).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_pend_q   <= 1'b0;
            cfg_period_q <= '0;
        end else if (cfg_we) begin
            cfg_pend_q   <= 1'b1;
            cfg_period_q <= cfg_period;
        end else if (cfg_clr) begin
            cfg_pend_q   <= 1'b0;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a small UART status model on the bus.
module tb_uart_tx_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        cfg_we;
    logic [7:0]  cfg_period;
    logic        u_wren;
    logic        u_rden;
    logic [2:0]  u_addr;
    logic [7:0]  u_din;
    logic [7:0]  u_dout = 8'h00;
    logic        busy;
    logic [1:0]  grant_id;

    int n_chk  = 0;
    int n_pass = 0;

    // Status reads return TXFULL=1 while rd_count < busy_reads; upper bits are junk.
    int rd_count   = 0;
    int busy_reads = 0;

    uart_tx_arb dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .cfg_we     (cfg_we),
        .cfg_period (cfg_period),
        .u_wren     (u_wren),
        .u_rden     (u_rden),
        .u_addr     (u_addr),
        .u_din      (u_din),
        .u_dout     (u_dout),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (u_rden) begin
            u_dout   <= {7'h55, (rd_count < busy_reads)};
            rd_count <= rd_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    task automatic check_bus(input string tag, input logic wr, input logic rd,
                             input logic [2:0] addr, input logic [7:0] din);
        check(tag, {19'b0, u_wren, u_rden, u_addr, u_din}, {19'b0, wr, rd, addr, din});
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [7:0] exp_bytes [4];
    int         base_rd;

    initial begin
        reset_n    = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        cfg_we     = 1'b0;
        cfg_period = '0;
        exp_bytes[0] = 8'hA0;
        exp_bytes[1] = 8'hB1;
        exp_bytes[2] = 8'hC2;
        exp_bytes[3] = 8'hD3;

        // Reset values
        repeat (2) next();
        settle();
        check_bus("rst_bus", 0, 0, 3'd0, 8'h00);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_grant", 32'(grant_id), 32'd3);
        check("rst_busy", 32'(busy), 32'd1);

        // First cycle after release is the INIT period write
        next(); reset_n = 1'b1; settle();
        check_bus("init_wr", 1, 0, 3'd0, 8'h1A);
        check("init_ready", 32'(req_ready), 32'h0);
        next(); settle();
        check_bus("idle_bus0", 0, 0, 3'd0, 8'h00);
        check("idle_busy", 32'(busy), 32'd0);
        next(); settle();
        check_bus("idle_bus1", 0, 0, 3'd0, 8'h00);

        // Single byte from requester 0
        next(); req_valid = 4'b0001; req_data = 32'h0000_0055; settle();
        check("r0_ready", 32'(req_ready), 32'h1);
        check_bus("r0_idle_bus", 0, 0, 3'd0, 8'h00);
        next(); req_valid = '0; settle();
        check_bus("r0_stat", 0, 1, 3'd3, 8'h00);
        check("r0_grant", 32'(grant_id), 32'd0);
        check("r0_stat_ready", 32'(req_ready), 32'h0);
        next(); settle();
        check_bus("r0_check", 0, 0, 3'd0, 8'h00);
        next(); settle();
        check_bus("r0_write", 1, 0, 3'd1, 8'h55);
        next(); settle();
        check_bus("r0_after", 0, 0, 3'd0, 8'h00);
        check("r0_after_busy", 32'(busy), 32'd0);

        // Reset while a byte from requester 2 is in flight abandons it
        next(); req_valid = 4'b0100; req_data = 32'h00EE_0000; settle();
        check("ab_ready", 32'(req_ready), 32'h4);
        next(); req_valid = '0; settle();
        check("ab_grant", 32'(grant_id), 32'd2);
        next(); reset_n = 1'b0; settle();
        check_bus("ab_rst_bus", 0, 0, 3'd0, 8'h00);
        check("ab_rst_grant", 32'(grant_id), 32'd3);
        next(); reset_n = 1'b1; settle();
        check_bus("ab_init_wr", 1, 0, 3'd0, 8'h1A);
        next(); settle();
        check_bus("ab_no_wr0", 0, 0, 3'd0, 8'h00);
        next(); settle();
        check_bus("ab_no_wr1", 0, 0, 3'd0, 8'h00);

        // All four requesters held valid: grants 0,1,2,3,0 every 4 cycles
        next(); req_valid = 4'b1111; req_data = 32'hD3C2_B1A0;
        for (int g = 0; g < 5; g++) begin
            if (g != 0) next();
            settle();
            check($sformatf("rr%0d_ready", g), 32'(req_ready), 32'(4'b0001 << (g % 4)));
            next(); settle();
            check_bus($sformatf("rr%0d_stat", g), 0, 1, 3'd3, 8'h00);
            check($sformatf("rr%0d_grant", g), 32'(grant_id), 32'(g % 4));
            check($sformatf("rr%0d_stat_rdy", g), 32'(req_ready), 32'h0);
            next(); settle();
            check($sformatf("rr%0d_chk_rdy", g), 32'(req_ready), 32'h0);
            next(); settle();
            check_bus($sformatf("rr%0d_write", g), 1, 0, 3'd1, exp_bytes[g % 4]);
        end
        next(); req_valid = '0; settle();
        check_bus("rr_done_bus", 0, 0, 3'd0, 8'h00);

        // TXFULL for three status reads, then one write
        base_rd    = rd_count;
        busy_reads = rd_count + 3;
        next(); req_valid = 4'b0001; req_data = 32'h0000_0077; settle();
        check("full_ready", 32'(req_ready), 32'h1);
        next(); settle();
        for (int r = 0; r < 3; r++) begin
            check_bus($sformatf("full_stat%0d", r), 0, 1, 3'd3, 8'h00);
            check($sformatf("full_stat_rdy%0d", r), 32'(req_ready), 32'h0);
            next(); settle();
            check_bus($sformatf("full_check%0d", r), 0, 0, 3'd0, 8'h00);
            check($sformatf("full_chk_rdy%0d", r), 32'(req_ready), 32'h0);
            next(); settle();
        end
        check_bus("full_stat_last", 0, 1, 3'd3, 8'h00);
        next(); settle();
        check_bus("full_check_last", 0, 0, 3'd0, 8'h00);
        next(); req_valid = '0; settle();
        check_bus("full_write", 1, 0, 3'd1, 8'h77);
        next(); settle();
        check_bus("full_after", 0, 0, 3'd0, 8'h00);
        check("full_reads", 32'(rd_count - base_rd), 32'd4);

        // cfg during CHECK: in-flight byte first, then period write, then requester 2
        next(); req_valid = 4'b0100; req_data = 32'h002C_0000; settle();
        check("cf_ready", 32'(req_ready), 32'h4);
        next(); settle();
        check_bus("cf_stat", 0, 1, 3'd3, 8'h00);
        next(); cfg_we = 1'b1; cfg_period = 8'h0C; settle();
        check_bus("cf_check", 0, 0, 3'd0, 8'h00);
        next(); cfg_we = 1'b0; settle();
        check_bus("cf_byte_wr", 1, 0, 3'd1, 8'h2C);
        next(); settle();
        check("cf_idle_ready", 32'(req_ready), 32'h0);
        check_bus("cf_idle_bus", 0, 0, 3'd0, 8'h00);
        next(); settle();
        check_bus("cf_period_wr", 1, 0, 3'd0, 8'h0C);
        check("cf_cfg_ready", 32'(req_ready), 32'h0);
        check("cf_cfg_busy", 32'(busy), 32'd1);
        next(); settle();
        check("cf_regrant", 32'(req_ready), 32'h4);
        next(); req_valid = '0; settle();
        check_bus("cf_stat2", 0, 1, 3'd3, 8'h00);
        next(); next(); settle();
        check_bus("cf_byte_wr2", 1, 0, 3'd1, 8'h2C);

        // Two cfg requests before service: the later value is written
        next(); cfg_we = 1'b1; cfg_period = 8'h11; settle();
        check_bus("lw_idle0", 0, 0, 3'd0, 8'h00);
        next(); cfg_period = 8'h22; settle();
        check_bus("lw_idle1", 0, 0, 3'd0, 8'h00);
        next(); cfg_we = 1'b0; settle();
        check_bus("lw_write", 1, 0, 3'd0, 8'h22);
        next(); settle();
        check_bus("lw_after0", 0, 0, 3'd0, 8'h00);
        next(); settle();
        check_bus("lw_after1", 0, 0, 3'd0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
